// File: rtl/phy_link_ctrl_if.sv
// phy_link_ctrl_if: word stream and link status bundle for phy_link_ctrl.
//   word_in, word_valid, code_err     : recovered byte stream (master drives)
//   active, idle_out, lock_lost       : link status (slave drives)
//   err_count, state_out              : error counter and debug state (slave drives)
interface phy_link_ctrl_if;
    logic [7:0] word_in;
    logic       word_valid;
    logic       code_err;
    logic       active;
    logic       idle_out;
    logic       lock_lost;
    logic [7:0] err_count;
    logic [1:0] state_out;

    modport master (
        output word_in, word_valid, code_err,
        input  active, idle_out, lock_lost, err_count, state_out
    );

    modport slave (
        input  word_in, word_valid, code_err,
        output active, idle_out, lock_lost, err_count, state_out
    );
endinterface

// File: rtl/phy_link_ctrl.sv
// phy_link_ctrl: word-sync / link-state controller for the PHY lane.
//   clk_4f : word-rate clock
//   reset  : asynchronous active-low reset
//   link   : phy_link_ctrl_if.slave (word_in/word_valid/code_err in;
//            active/idle_out/lock_lost/err_count/state_out out)
// Optional feature macro: PHY_LINK_ERRCNT_EN enables the saturating
// code-error counter on err_count; otherwise err_count is tied to 0.
//
// state   | meaning
// SEARCH  | hunting for the first clean BC comma
// CHECK   | counting consecutive clean BC commas toward lock
// LOCKED  | link up; counting consecutive code errors toward loss
module phy_link_ctrl #(
    parameter logic [7:0] BC_CODE    = 8'hBC,
    parameter logic [7:0] IDL_CODE   = 8'h7C,
    parameter int         LOCK_COUNT = 4,
    parameter int         LOSS_COUNT = 3
) (
    input  logic          clk_4f,
    input  logic          reset,
    phy_link_ctrl_if.slave link
);
    localparam logic [1:0] SEARCH = 2'd0;
    localparam logic [1:0] CHECK  = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;

    localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);
    localparam logic [3:0] LOSS_N = 4'(LOSS_COUNT);

    logic [1:0] state, state_nxt;
    logic [3:0] bc_cnt, bc_nxt;
    logic [3:0] err_run, err_nxt;
    logic       idle_q, idle_nxt;
    logic       lost_q, lost_nxt;
    logic       clean;
    logic       clean_bc;
    logic       clean_idle;

    // code_err outranks any character match
    assign clean      = link.word_valid && !link.code_err;
    assign clean_bc   = clean && (link.word_in == BC_CODE);
    assign clean_idle = clean && ((link.word_in == BC_CODE) || (link.word_in == IDL_CODE));

    always_comb begin
        state_nxt = state;
        bc_nxt    = bc_cnt;
        err_nxt   = err_run;
        lost_nxt  = 1'b0;
        idle_nxt  = idle_q;
        case (state)
            SEARCH: begin
                if (link.word_valid) begin
                    if (clean_bc) begin
                        bc_nxt    = 4'd1;
                        state_nxt = (LOCK_N == 4'd1) ? LOCKED : CHECK;
                    end else begin
                        bc_nxt = 4'd0;
                    end
                end
            end
            CHECK: begin
                if (link.word_valid) begin
                    if (clean_bc) begin
                        bc_nxt = bc_cnt + 4'd1;
                        if (bc_cnt + 4'd1 == LOCK_N)
                            state_nxt = LOCKED;
                    end else begin
                        bc_nxt    = 4'd0;
                        state_nxt = SEARCH;
                    end
                end
            end
            LOCKED: begin
                if (link.word_valid) begin
                    if (link.code_err) begin
                        if (err_run + 4'd1 == LOSS_N) begin
                            state_nxt = SEARCH;
                            bc_nxt    = 4'd0;
                            err_nxt   = 4'd0;
                            lost_nxt  = 1'b1;
                        end else begin
                            err_nxt = err_run + 4'd1;
                        end
                    end else begin
                        err_nxt = 4'd0;
                    end
                end
            end
            default: begin
                state_nxt = SEARCH;
                bc_nxt    = 4'd0;
                err_nxt   = 4'd0;
            end
        endcase

        if (link.word_valid)
            idle_nxt = clean_idle;
        if (state_nxt != LOCKED)
            idle_nxt = 1'b0;
    end

    always_ff @(posedge clk_4f or negedge reset) begin
        if (!reset) begin
            state   <= SEARCH;
            bc_cnt  <= 4'd0;
            err_run <= 4'd0;
            idle_q  <= 1'b0;
            lost_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            bc_cnt  <= bc_nxt;
            err_run <= err_nxt;
            idle_q  <= idle_nxt;
            lost_q  <= lost_nxt;
        end
    end

    assign link.active    = (state == LOCKED);
    assign link.idle_out  = idle_q;
    assign link.lock_lost = lost_q;
    assign link.state_out = state;

`ifdef PHY_LINK_ERRCNT_EN
    logic [7:0] err_cnt;

    always_ff @(posedge clk_4f or negedge reset) begin
        if (!reset)
            err_cnt <= 8'h00;
        else if (link.word_valid && link.code_err && (err_cnt != 8'hFF))
            err_cnt <= err_cnt + 8'h01;
    end

    assign link.err_count = err_cnt;
`else
    assign link.err_count = 8'h00;
`endif
endmodule

// File: doc/phy_link_ctrl.md
Name: phy_link_ctrl

Overview:
Link-state controller for the PHY transmit/receive pair. It watches the byte stream recovered by the serial-to-parallel stage at clk_4f, declares word sync after a run of BC comma characters, and drives `active`, the recirculation/muxing enable that switches the lane recirculator from "desactivado" to "activo". It also flags idle periods and drops the link after repeated code errors, so the datapath is sequenced purely by this block.

Parameters:
- BC_CODE, 8'hBC, comma/sync character.
- IDL_CODE, 8'h7C, idle character.
- LOCK_COUNT, 4, consecutive BC words required to lock (legal range 1..15).
- LOSS_COUNT, 3, consecutive code-error words that drop lock (legal range 1..15).

Ports:
- clk_4f  in  1  word-rate clock; sole clock.
- reset  in  1  asynchronous, active-low reset.
- word_in  in  8  recovered byte from serial-to-parallel.
- word_valid  in  1  word_in is a new word this cycle; otherwise ignore the cycle.
- code_err  in  1  qualified by word_valid; upstream reports an invalid code word.
- active  out  1  link locked; enables recirculator/mux/parallel-serial path.
- idle_out  out  1  locked, and the last valid word was BC or IDL.
- lock_lost  out  1  one-cycle pulse when LOCKED drops to SEARCH.
- err_count  out  8  code-error counter (see Optional Feature).
- state_out  out  2  current state encoding, for debug.

Behaviour:
- Reset (reset=0, asynchronous): state=SEARCH; all counters 0; active=0, idle_out=0, lock_lost=0, err_count=0, state_out=2'd0. Release is taken on the next clk_4f edge.
- States and encoding: SEARCH=0, CHECK=1, LOCKED=2. Encoding 3 is illegal and recovers to SEARCH on the next edge.
- All outputs are registered. A decision on a word sampled at edge N is visible after edge N.
- Cycles with word_valid=0 change no state and no counter. lock_lost is still cleared to 0 on these cycles.
- SEARCH:
  - A valid word with word_in==BC_CODE and code_err=0 sets bc_cnt=1 and moves to CHECK. If LOCK_COUNT==1, it goes directly to LOCKED.
  - Any other valid word leaves bc_cnt=0 and stays in SEARCH.
- CHECK:
  - A valid BC word increments bc_cnt. When bc_cnt+1==LOCK_COUNT, move to LOCKED and set active=1 on that edge.
  - Any non-BC valid word, or any word with code_err=1, clears bc_cnt and returns to SEARCH.
- LOCKED:
  - active=1.
  - A valid word with code_err=1 increments err_run (4-bit).
  - A valid word with code_err=0 clears err_run.
  - When err_run+1==LOSS_COUNT on an error word: move to SEARCH, set active=0, pulse lock_lost=1 for one cycle, clear bc_cnt and err_run.
  - idle_out is updated on each valid word: 1 if word_in is BC_CODE or IDL_CODE and code_err=0, else 0. idle_out is forced to 0 outside LOCKED.
- BC words while LOCKED do not affect lock; they only mark idle.
- Simultaneous events: code_err has priority over BC/IDL matching. A BC word carrying code_err counts as an error, never as a comma.
- Mid-operation reset clears the state instantly (asynchronous): active drops without a lock_lost pulse.
- Counters never wrap: bc_cnt and err_run are bounded by their parameter compares.

Optional Feature:
- Macro: PHY_LINK_ERRCNT_EN.
- Defined:
  - err_count is an 8-bit saturating counter incremented on every valid word with code_err=1, in any state.
  - It holds at 8'hFF and is cleared only by reset.
- Undefined:
  - err_count is tied to 8'h00 and no counter logic is synthesized.
  - All other behaviour is identical.

Test Plan:
- Lock: after reset, apply 4 valid BC words on consecutive cycles -> state_out 0->1->1->1->2; active=1 after the 4th edge; idle_out=1.
- Broken run: BC, BC, 8'h55, then BC ×4 -> returns to SEARCH after the 3rd word; active rises only after the 7th word.
- Gaps: BC words interleaved with word_valid=0 cycles -> the gaps are ignored; lock is reached after the 4th valid BC, with no early assertion.
- Loss: in LOCKED, send data 8'hA5, then 3 words with code_err=1 -> active=0 and lock_lost=1 for exactly one cycle after the 3rd error. Separately, err, ok, err, err does not drop lock.
- Idle tracking: in LOCKED, send 8'h7C then 8'h12 -> idle_out 1 then 0, and active stays 1.
- Async reset in LOCKED: reset=0 mid-cycle -> active=0 immediately, lock_lost stays 0. With PHY_LINK_ERRCNT_EN, 300 error words give err_count=8'hFF.
